mem_handle_server: RTL and testbench

//  Responder end of the mem_handle interface. Accepts single-word load/store requests from one

---
 rtl/mem_handle_pkg.sv | 49 ++++
 rtl/mem_cache_array.sv | 30 +++
 rtl/mem_handle_server.sv | 276 +++++++++++++++++++++++++++
 tb/tb_mem_handle_server.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_handle_pkg.sv
// Shared constants, FSM/operation encodings and the cache line record for
// the mem_handle responder (mem_handle_server and mem_cache_array).
package mem_handle_pkg;

  localparam int ADDR_W     = 23;
  localparam int DATA_W     = 32;
  localparam int CACHE_BITS = 3;
  localparam int CACHE_SIZE = 1 << CACHE_BITS;
  localparam int TAG_W      = ADDR_W - CACHE_BITS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_THRU_W = 3'd4,
    S_THRU_R = 3'd5,
    S_FLUSH  = 3'd6,
    S_RESP   = 3'd7
  } state_e;

  // Operation decoded once at accept; selects where a write-back continues.
  typedef enum logic [2:0] {
    OP_READ  = 3'd0,
    OP_WRITE = 3'd1,
    OP_WTHRU = 3'd2,
    OP_RTHRU = 3'd3,
    OP_FLUSH = 3'd4
  } op_e;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cache_line_t;

  // Build a valid line with the given dirty state.
  function automatic cache_line_t make_line(input logic dirty, input logic [TAG_W-1:0] tag,
                                            input logic [DATA_W-1:0] data);
    cache_line_t l;
    l.valid = 1'b1;
    l.dirty = dirty;
    l.tag   = tag;
    l.data  = data;
    return l;
  endfunction

endpackage

// File: rtl/mem_cache_array.sv
// Line storage for the direct-mapped cache: combinational read by index,
// one synchronous write port, every line invalidated on reset.
module mem_cache_array
  import mem_handle_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [CACHE_BITS-1:0] rd_idx_i,
  output cache_line_t           rd_line_o,
  input  logic                  we_i,
  input  logic [CACHE_BITS-1:0] wr_idx_i,
  input  cache_line_t           wr_line_i
);

  cache_line_t lines_q [CACHE_SIZE];

  // Line storage: cleared on reset, otherwise one line written per cycle.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < CACHE_SIZE; i++) begin
        lines_q[i] <= '0;
      end
    end else if (we_i) begin
      lines_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_line_o = lines_q[rd_idx_i];

endmodule

// File: rtl/mem_handle_server.sv
// Responder side of mem_handle: single-word loads/stores served through an
// 8-entry direct-mapped write-back cache backed by a req/ack memory bus.
// Optional feature: define MEM_HANDLE_BOUNDS_CHECK_EN to reject requests whose
// ptr lies outside [region_begin, region_end] with a bounds_err pulse.
module mem_handle_server
  import mem_handle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_l,
  input  logic [ADDR_W-1:0] mh_region_begin_i,
  input  logic [ADDR_W-1:0] mh_region_end_i,
  input  logic [ADDR_W-1:0] mh_ptr_i,
  input  logic              mh_w_en_i,
  input  logic              mh_r_en_i,
  input  logic              mh_write_through_i,
  input  logic              mh_read_through_i,
  input  logic [DATA_W-1:0] mh_data_store_i,
  output logic              mh_avail_o,
  output logic              mh_done_o,
  output logic [DATA_W-1:0] mh_data_load_o,
  input  logic              flush_i,
  output logic              bounds_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e                state_q;
  op_e                   op_q;
  logic [ADDR_W-1:0]     ptr_q;
  logic [DATA_W-1:0]     store_q;
  logic                  oob_q;
  logic [CACHE_BITS-1:0] scan_q;
  logic                  avail_q, done_q, bounds_err_q;
  logic [DATA_W-1:0]     data_load_q;
  logic                  mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic                  arr_we_q;
  logic [CACHE_BITS-1:0] arr_idx_q;
  cache_line_t           arr_line_q;

  logic [CACHE_BITS-1:0] rd_idx_s;
  logic [CACHE_BITS-1:0] ptr_idx_s;
  logic [TAG_W-1:0]      ptr_tag_s;
  cache_line_t           rd_line_s;
  logic                  hit_s, victim_dirty_s, oob_s, scan_last_s;

  // Flush scans by its own index; every other operation looks at ptr's line.
  assign ptr_idx_s      = ptr_q[CACHE_BITS-1:0];
  assign ptr_tag_s      = ptr_q[ADDR_W-1:CACHE_BITS];
  assign rd_idx_s       = (op_q == OP_FLUSH) ? scan_q : ptr_idx_s;
  assign hit_s          = rd_line_s.valid && (rd_line_s.tag == ptr_tag_s);
  assign victim_dirty_s = rd_line_s.valid && rd_line_s.dirty;
  assign scan_last_s    = (scan_q == {CACHE_BITS{1'b1}});

`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
  assign oob_s        = (mh_ptr_i < mh_region_begin_i) || (mh_ptr_i > mh_region_end_i);
  assign bounds_err_o = bounds_err_q;
`else
  logic unused_bounds_s;
  assign oob_s           = 1'b0;
  assign bounds_err_o    = 1'b0;
  assign unused_bounds_s = ^{mh_region_begin_i, mh_region_end_i, bounds_err_q};
`endif

  mem_cache_array u_array (
    .clk       (clk),
    .rst_l     (rst_l),
    .rd_idx_i  (rd_idx_s),
    .rd_line_o (rd_line_s),
    .we_i      (arr_we_q),
    .wr_idx_i  (arr_idx_q),
    .wr_line_i (arr_line_q)
  );

  // Request FSM, backing-bus driver and registered handle outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= S_IDLE;
      op_q         <= OP_READ;
      ptr_q        <= '0;
      store_q      <= '0;
      oob_q        <= 1'b0;
      scan_q       <= '0;
      avail_q      <= 1'b1;
      done_q       <= 1'b0;
      bounds_err_q <= 1'b0;
      data_load_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      arr_we_q     <= 1'b0;
      arr_idx_q    <= '0;
      arr_line_q   <= '0;
    end else begin
      done_q       <= 1'b0;
      bounds_err_q <= 1'b0;
      arr_we_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (avail_q && (mh_w_en_i || mh_r_en_i)) begin
            ptr_q   <= mh_ptr_i;
            store_q <= mh_data_store_i;
            oob_q   <= oob_s;
            avail_q <= 1'b0;
            state_q <= S_LOOKUP;
            if (mh_w_en_i) op_q <= mh_write_through_i ? OP_WTHRU : OP_WRITE;
            else           op_q <= mh_read_through_i  ? OP_RTHRU : OP_READ;
          end else if (avail_q && flush_i) begin
            op_q    <= OP_FLUSH;
            scan_q  <= '0;
            oob_q   <= 1'b0;
            avail_q <= 1'b0;
            state_q <= S_FLUSH;
          end
        end
        S_LOOKUP: begin
          if (oob_q) begin
            data_load_q  <= '0;
            bounds_err_q <= 1'b1;
            done_q       <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            case (op_q)
              OP_READ: begin
                if (hit_s) begin
                  data_load_q <= rd_line_s.data;
                  done_q      <= 1'b1;
                  state_q     <= S_RESP;
                end else begin
                  state_q <= victim_dirty_s ? S_WB : S_FILL;
                end
              end
              OP_WRITE: begin
                if (!hit_s && victim_dirty_s) begin
                  state_q <= S_WB;
                end else begin
                  arr_we_q   <= 1'b1;
                  arr_idx_q  <= ptr_idx_s;
                  arr_line_q <= make_line(1'b1, ptr_tag_s, store_q);
                  done_q     <= 1'b1;
                  state_q    <= S_RESP;
                end
              end
              OP_WTHRU: state_q <= S_THRU_W;
              OP_RTHRU: state_q <= (hit_s && rd_line_s.dirty) ? S_WB : S_THRU_R;
              default: begin
                done_q  <= 1'b1;
                state_q <= S_RESP;
              end
            endcase
          end
        end
        S_WB: begin
          if (!mem_req_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {rd_line_s.tag, rd_idx_s};
            mem_wdata_q <= rd_line_s.data;
          end else if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            case (op_q)
              OP_READ: state_q <= S_FILL;
              OP_WRITE: begin
                arr_we_q   <= 1'b1;
                arr_idx_q  <= ptr_idx_s;
                arr_line_q <= make_line(1'b1, ptr_tag_s, store_q);
                done_q     <= 1'b1;
                state_q    <= S_RESP;
              end
              OP_RTHRU: begin
                arr_we_q   <= 1'b1;
                arr_idx_q  <= rd_idx_s;
                arr_line_q <= make_line(1'b0, rd_line_s.tag, rd_line_s.data);
                state_q    <= S_THRU_R;
              end
              OP_FLUSH: begin
                arr_we_q   <= 1'b1;
                arr_idx_q  <= rd_idx_s;
                arr_line_q <= make_line(1'b0, rd_line_s.tag, rd_line_s.data);
                if (scan_last_s) begin
                  done_q  <= 1'b1;
                  state_q <= S_RESP;
                end else begin
                  scan_q  <= scan_q + {{(CACHE_BITS-1){1'b0}}, 1'b1};
                  state_q <= S_FLUSH;
                end
              end
              default: begin
                done_q  <= 1'b1;
                state_q <= S_RESP;
              end
            endcase
          end
        end
        S_FILL: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= ptr_q;
          end else if (mem_ack_i) begin
            mem_req_q   <= 1'b0;
            arr_we_q    <= 1'b1;
            arr_idx_q   <= ptr_idx_s;
            arr_line_q  <= make_line(1'b0, ptr_tag_s, mem_rdata_i);
            data_load_q <= mem_rdata_i;
            done_q      <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_THRU_W: begin
          if (!mem_req_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ptr_q;
            mem_wdata_q <= store_q;
          end else if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            if (hit_s) begin
              arr_we_q   <= 1'b1;
              arr_idx_q  <= ptr_idx_s;
              arr_line_q <= make_line(1'b0, ptr_tag_s, store_q);
            end
            done_q  <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_THRU_R: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= ptr_q;
          end else if (mem_ack_i) begin
            mem_req_q   <= 1'b0;
            data_load_q <= mem_rdata_i;
            done_q      <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_FLUSH: begin
          if (victim_dirty_s) begin
            state_q <= S_WB;
          end else if (scan_last_s) begin
            done_q  <= 1'b1;
            state_q <= S_RESP;
          end else begin
            scan_q <= scan_q + {{(CACHE_BITS-1){1'b0}}, 1'b1};
          end
        end
        S_RESP: begin
          avail_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          avail_q   <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign mh_avail_o     = avail_q;
  assign mh_done_o      = done_q;
  assign mh_data_load_o = data_load_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;

endmodule

// File: tb/tb_mem_handle_server.sv
// Directed bench for mem_handle_server: architectural memory model (last
// value written per address, reverting to backing contents on reset), a
// req/ack backing-memory responder with a transaction log, and a per-cycle
// compare process on done/data_load/bounds_err/avail.
module tb_mem_handle_server;

  logic        clk;
  logic        rst_l;
  logic [22:0] rb, re, ptr;
  logic        w_en, r_en, wt, rt, flush;
  logic [31:0] dstore;
  logic        avail, done, berr;
  logic [31:0] dload;
  logic        mem_req, mem_we, mem_ack;
  logic [22:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  mem_handle_server dut (
    .clk(clk), .rst_l(rst_l),
    .mh_region_begin_i(rb), .mh_region_end_i(re), .mh_ptr_i(ptr),
    .mh_w_en_i(w_en), .mh_r_en_i(r_en),
    .mh_write_through_i(wt), .mh_read_through_i(rt),
    .mh_data_store_i(dstore),
    .mh_avail_o(avail), .mh_done_o(done), .mh_data_load_o(dload),
    .flush_i(flush), .bounds_err_o(berr),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic chk_data; logic [31:0] data; logic berr; } exp_t;
  typedef struct packed { logic we; logic [22:0] addr; logic [31:0] data; } bus_t;

  exp_t        exp_q[$];
  bus_t        bus_log[$];
  logic [31:0] backing [logic [22:0]];
  logic [31:0] arch    [logic [22:0]];
  int          ack_delay;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] bk_read(input logic [22:0] a);
    if (backing.exists(a)) return backing[a];
    return 32'hC0DE_0000 ^ {9'd0, a};
  endfunction

  function automatic logic [31:0] arch_read(input logic [22:0] a);
    if (arch.exists(a)) return arch[a];
    return bk_read(a);
  endfunction

  task automatic chk_log(input string name, input int idx, input logic we_e,
                         input logic [22:0] a, input logic [31:0] d);
    if (idx >= bus_log.size()) begin
      checks++;
      failures++;
      $display("FAIL %s actual=missing_entry required=%0h/%0h/%0h", name, we_e, a, d);
    end else begin
      chk(name, {8'd0, bus_log[idx]}, {8'd0, we_e, a, d});
    end
  endtask

  // Backing memory responder: acks after ack_delay cycles and checks bus stability.
  initial begin
    logic        ack_given, held;
    int          cnt;
    logic [55:0] snap;
    mem_ack = 1'b0; mem_rdata = 32'd0; ack_given = 1'b0; held = 1'b0; cnt = 0; snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        mem_ack = 1'b0; ack_given = 1'b0; held = 1'b0; cnt = 0;
      end else if (ack_given) begin
        chk("mem_req_drop_after_ack", {63'd0, mem_req}, 64'd0);
        mem_ack = 1'b0; ack_given = 1'b0; held = 1'b0;
      end else if (mem_req) begin
        if (held) chk("mem_bus_stable", {8'd0, mem_we, mem_addr, mem_wdata}, {8'd0, snap});
        else begin snap = {mem_we, mem_addr, mem_wdata}; held = 1'b1; cnt = 0; end
        cnt++;
        if (cnt >= ack_delay) begin
          mem_ack = 1'b1; ack_given = 1'b1;
          if (mem_we) begin
            backing[mem_addr] = mem_wdata;
            bus_log.push_back({1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = bk_read(mem_addr);
            bus_log.push_back({1'b0, mem_addr, mem_rdata});
          end
        end
      end
    end
  end

  // Compare process: done pulse shape, avail return, data_load and bounds_err.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_l) prev_done = 1'b0;
      else begin
        if (prev_done) chk("avail_after_done", {63'd0, avail}, 64'd1);
        if (done) begin
          chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done actual=done required=no_pending_request");
          end else begin
            e = exp_q.pop_front();
            if (e.chk_data) chk("data_load", {32'd0, dload}, {32'd0, e.data});
            chk("bounds_err_on_done", {63'd0, berr}, {63'd0, e.berr});
          end
        end else begin
          chk("bounds_err_idle", {63'd0, berr}, 64'd0);
        end
        prev_done = done;
      end
    end
  end

  task automatic wait_avail();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!avail && n < 200);
    if (!avail) begin
      checks++; failures++;
      $display("FAIL avail_timeout actual=0 required=1");
    end
  endtask

  // Issue one request (or flush) and wait for done; lat counts cycles from accept.
  task automatic do_op(input logic w, input logic r, input logic wt_i, input logic rt_i,
                       input logic fl, input logic [22:0] p, input logic [31:0] d, output int lat);
    exp_t e;
    logic oob;
    wait_avail();
    oob = 1'b0;
`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
    if (!fl) oob = (p < rb) || (p > re);
`endif
    e.chk_data = r && !w && !fl;
    e.data     = oob ? 32'd0 : arch_read(p);
    e.berr     = oob;
    if (w && !oob && !fl) arch[p] = d;
    exp_q.push_back(e);
    ptr = p; dstore = d; w_en = w; r_en = r; wt = wt_i; rt = rt_i; flush = fl;
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0; wt = 1'b0; rt = 1'b0; flush = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin @(negedge clk); lat++; end
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  initial begin
    int lat, n0, n;
    rst_l = 1'b1; rb = 23'd0; re = 23'h7FFFFF; ptr = 23'd0; dstore = 32'd0;
    w_en = 1'b0; r_en = 1'b0; wt = 1'b0; rt = 1'b0; flush = 1'b0;
    ack_delay = 1;
    backing[23'h25] = 32'h0000_1234;
    #1 rst_l = 1'b0;
    #2;
    chk("rst_avail", {63'd0, avail}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_data_load", {32'd0, dload}, 64'd0);
    chk("rst_bounds_err", {63'd0, berr}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_addr", {41'd0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_l = 1'b1;

    // 1: write then read hit, no bus traffic, two-cycle latency
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h10, 32'hDEADBEEF, lat);
    chk("t1_wr_lat", lat, 2);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h10, 32'd0, lat);
    chk("t1_rd_lat", lat, 2);
    chk("t1_rd_data", {32'd0, dload}, 64'hDEADBEEF);
    chk("t1_no_bus", bus_log.size(), 0);
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 23'h10, 32'h0000_000C, lat);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h10, 32'd0, lat);
    chk("t1_wr_rd_is_write", {32'd0, dload}, 64'hC);

    // 2: conflicting write evicts the dirty line first
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h10, 32'h0000_000A, lat);
    n0 = bus_log.size();
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h18, 32'h0000_000B, lat);
    chk("t2_bus_count", bus_log.size(), n0 + 1);
    chk_log("t2_wb", n0, 1'b1, 23'h10, 32'h0000_000A);

    // 3: read miss with slow ack, reread hits; dirty-victim read miss
    ack_delay = 3;
    n0 = bus_log.size();
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h25, 32'd0, lat);
    chk("t3_fill_data", {32'd0, dload}, 64'h1234);
    chk_log("t3_fill", n0, 1'b0, 23'h25, 32'h0000_1234);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h25, 32'd0, lat);
    chk("t3_reread_lat", lat, 2);
    chk("t3_reread_bus", bus_log.size(), n0 + 1);
    ack_delay = 1;
    n0 = bus_log.size();
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h08, 32'd0, lat);
    chk_log("t3_victim_wb", n0, 1'b1, 23'h18, 32'h0000_000B);
    chk_log("t3_victim_fill", n0 + 1, 1'b0, 23'h08, 32'hC0DE_0008);

    // 4: write-through miss (no allocate) and hit (line clean), then flush
    n0 = bus_log.size();
    do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 23'h07, 32'h0000_0055, lat);
    chk_log("t4_wt_miss", n0, 1'b1, 23'h07, 32'h0000_0055);
    do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 23'h25, 32'h0000_0099, lat);
    chk_log("t4_wt_hit", n0 + 1, 1'b1, 23'h25, 32'h0000_0099);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h25, 32'd0, lat);
    chk("t4_reread_lat", lat, 2);
    chk("t4_reread_data", {32'd0, dload}, 64'h99);
    n0 = bus_log.size();
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 23'd0, 32'd0, lat);
    chk("t4_flush_no_writes", bus_log.size(), n0);

    // 5: flush writes dirty lines in index order; read-through paths
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h21, 32'h0000_0011, lat);
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h4C, 32'h0000_0044, lat);
    n0 = bus_log.size();
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 23'd0, 32'd0, lat);
    chk("t5_flush_count", bus_log.size(), n0 + 2);
    chk_log("t5_flush_idx1", n0, 1'b1, 23'h21, 32'h0000_0011);
    chk_log("t5_flush_idx4", n0 + 1, 1'b1, 23'h4C, 32'h0000_0044);
    n0 = bus_log.size();
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 23'd0, 32'd0, lat);
    chk("t5_reflush_none", bus_log.size(), n0);
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h21, 32'h0000_0077, lat);
    n0 = bus_log.size();
    do_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 23'h21, 32'd0, lat);
    chk_log("t5_rt_wb", n0, 1'b1, 23'h21, 32'h0000_0077);
    chk_log("t5_rt_read", n0 + 1, 1'b0, 23'h21, 32'h0000_0077);
    n0 = bus_log.size();
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 23'd0, 32'd0, lat);
    chk("t5_rt_left_clean", bus_log.size(), n0);
    do_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 23'h05, 32'd0, lat);
    chk_log("t5_rt_miss", n0, 1'b0, 23'h05, 32'hC0DE_0005);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h05, 32'd0, lat);
    chk("t5_rt_no_alloc", bus_log.size(), n0 + 2);

    // 6: reset during FILL aborts the request and drops dirty data
    ack_delay = 10;
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h3A, 32'h0000_5A5A, lat);
    wait_avail();
    ptr = 23'h33; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    chk("t6_fill_started", {63'd0, mem_req}, 64'd1);
    @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    chk("t6_rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("t6_rst_avail", {63'd0, avail}, 64'd1);
    chk("t6_rst_done", {63'd0, done}, 64'd0);
    exp_q.delete();
    arch.delete();
    @(negedge clk); @(negedge clk);
    rst_l = 1'b1;
    ack_delay = 1;
    n0 = bus_log.size();
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h33, 32'd0, lat);
    chk_log("t6_reread_miss", n0, 1'b0, 23'h33, 32'hC0DE_0033);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h3A, 32'd0, lat);
    chk("t6_dirty_lost", {32'd0, dload}, 64'hC0DE_003A);
    chk("t6_no_wb_after_rst", bus_log.size(), n0 + 2);

`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
    // Region check: out-of-range requests touch nothing
    rb = 23'h100; re = 23'h1FF;
    n0 = bus_log.size();
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h200, 32'd0, lat);
    chk("tb_oob_lat", lat, 2);
    chk("tb_oob_data", {32'd0, dload}, 64'd0);
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0FF, 32'h0000_0123, lat);
    chk("tb_oob_no_bus", bus_log.size(), n0);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h1FF, 32'd0, lat);
    chk_log("tb_in_range", n0, 1'b0, 23'h1FF, 32'hC0DE_01FF);
    rb = 23'd0; re = 23'h7FFFFF;
`endif

    wait_avail();
    chk("pending_requests", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
